// File: rtl/micro_seq_pkg.sv
// Shared definitions for the multicycle MIPS micro-sequencer and its datapath.
// Contents: micro-state addresses, next-address codes, opcode constants,
// datapath select encodings and the microcode word layout.
package micro_defs;

    // Micro-state addresses (uPC values).
    localparam int S_FETCH     = 0;
    localparam int S_DECODE    = 1;
    localparam int S_MEM_ADDR  = 2;
    localparam int S_LW_READ   = 3;
    localparam int S_LW_WB     = 4;
    localparam int S_SW_WRITE  = 5;
    localparam int S_R_EXEC    = 6;
    localparam int S_R_WB      = 7;
    localparam int S_BEQ       = 8;
    localparam int S_J         = 9;
    localparam int S_JAL       = 10;
    localparam int S_ADDI_EXEC = 11;
    localparam int S_ADDI_WB   = 12;

    // Opcodes, IR[31:26].
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        NA_FETCH = 2'd0,
        NA_DISP1 = 2'd1,
        NA_DISP2 = 2'd2,
        NA_SEQ   = 2'd3
    } next_e;

    typedef enum logic [1:0] {
        REG_DST_RT   = 2'd0,
        REG_DST_RD   = 2'd1,
        REG_DST_R31  = 2'd2,
        REG_DST_RSVD = 2'd3
    } reg_dst_e;

    typedef enum logic [1:0] {
        M2R_ALUOUT = 2'd0,
        M2R_MDR    = 2'd1,
        M2R_PC     = 2'd2
    } mem_to_reg_e;

    typedef enum logic [1:0] {
        SRCB_B      = 2'd0,
        SRCB_FOUR   = 2'd1,
        SRCB_IMM    = 2'd2,
        SRCB_IMM_SH = 2'd3
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_JUMP   = 2'd2
    } pc_src_e;

    // One microcode word. mem_state marks words that wait on mem_ready.
    typedef struct packed {
        logic        mem_state;
        logic        mem_read;
        logic        mem_write;
        logic        ir_write;
        logic        reg_write;
        logic        pc_write;
        logic        branch;
        logic        iord;
        reg_dst_e    reg_dst;
        mem_to_reg_e mem_to_reg;
        logic        alu_src_a;
        alu_src_b_e  alu_src_b;
        alu_op_e     alu_op;
        pc_src_e     pc_src;
        next_e       next;
    } ctrl_word_t;

endpackage

// File: rtl/micro_seq_if.sv
// Control bus between the micro-sequencer (master) and the datapath (slave).
// Inputs to the sequencer: op, zero, mem_ready.
// Outputs from the sequencer: all control strobes/selects, upc, illegal_op.
interface micro_seq_if #(parameter int UPC_W = 4);
    logic [5:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             pc_en;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_src;
    logic [UPC_W-1:0] upc;
    logic             illegal_op;

    modport master (
        input  op, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               upc, illegal_op
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               upc, illegal_op
    );
endinterface

// File: rtl/micro_seq_rom.sv
// Microcode ROM: maps the current uPC to its control word and next-address
// code. Purely combinational.
// Ports: upc (in) current micro-PC; word (out) microcode word.
module micro_rom
    import micro_defs::*;
#(
    parameter int UPC_W = 4
) (
    input  logic [UPC_W-1:0] upc,
    output ctrl_word_t       word
);

    always_comb begin
        word = '0;
        word.next = NA_FETCH;
        case (upc)
            UPC_W'(S_FETCH): begin
                word.mem_state = 1'b1;
                word.mem_read  = 1'b1;
                word.ir_write  = 1'b1;
                word.pc_write  = 1'b1;
                word.alu_src_b = SRCB_FOUR;
                word.next      = NA_SEQ;
            end
            UPC_W'(S_DECODE): begin
                word.alu_src_b = SRCB_IMM_SH;
                word.next      = NA_DISP1;
            end
            UPC_W'(S_MEM_ADDR): begin
                word.alu_src_a = 1'b1;
                word.alu_src_b = SRCB_IMM;
                word.next      = NA_DISP2;
            end
            UPC_W'(S_LW_READ): begin
                word.mem_state = 1'b1;
                word.mem_read  = 1'b1;
                word.iord      = 1'b1;
                word.next      = NA_SEQ;
            end
            UPC_W'(S_LW_WB): begin
                word.reg_write  = 1'b1;
                word.reg_dst    = REG_DST_RT;
                word.mem_to_reg = M2R_MDR;
            end
            UPC_W'(S_SW_WRITE): begin
                word.mem_state = 1'b1;
                word.mem_write = 1'b1;
                word.iord      = 1'b1;
            end
            UPC_W'(S_R_EXEC): begin
                word.alu_src_a = 1'b1;
                word.alu_src_b = SRCB_B;
                word.alu_op    = ALU_FUNCT;
                word.next      = NA_SEQ;
            end
            UPC_W'(S_R_WB): begin
                word.reg_write  = 1'b1;
                word.reg_dst    = REG_DST_RD;
                word.mem_to_reg = M2R_ALUOUT;
            end
            UPC_W'(S_BEQ): begin
                word.alu_src_a = 1'b1;
                word.alu_src_b = SRCB_B;
                word.alu_op    = ALU_SUB;
                word.branch    = 1'b1;
                word.pc_src    = PCSRC_ALUOUT;
            end
            UPC_W'(S_J): begin
                word.pc_write = 1'b1;
                word.pc_src   = PCSRC_JUMP;
            end
            UPC_W'(S_JAL): begin
                // Link and jump together: r31 <= PC+4 while PC <= target.
                word.reg_write  = 1'b1;
                word.reg_dst    = REG_DST_R31;
                word.mem_to_reg = M2R_PC;
                word.pc_write   = 1'b1;
                word.pc_src     = PCSRC_JUMP;
            end
            UPC_W'(S_ADDI_EXEC): begin
                word.alu_src_a = 1'b1;
                word.alu_src_b = SRCB_IMM;
                word.next      = NA_SEQ;
            end
            UPC_W'(S_ADDI_WB): begin
                word.reg_write  = 1'b1;
                word.reg_dst    = REG_DST_RT;
                word.mem_to_reg = M2R_ALUOUT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/micro_seq.sv
// Microprogrammed control sequencer for the multicycle MIPS datapath.
// Ports: clk, rst (sync, active-high); bus (micro_seq_if.master) carrying
// op/zero/mem_ready in and all control strobes, selects, upc and
// illegal_op out. Outputs decode the current uPC (Moore form).
//
//  upc | meaning
//  ----+-------------------------------------------
//   0  | FETCH      read instr, IR<=mem, PC<=PC+4
//   1  | DECODE     branch target, dispatch on op
//   2  | MEM_ADDR   A+imm, dispatch LW/SW
//   3  | LW_READ    read data memory
//   4  | LW_WB      rt <= MDR
//   5  | SW_WRITE   write data memory
//   6  | R_EXEC     A funct B
//   7  | R_WB       rd <= ALUOut
//   8  | BEQ        compare, conditional PC load
//   9  | J          PC <= jump target
//  10  | JAL        r31 <= PC, PC <= jump target
//  11  | ADDI_EXEC  A+imm
//  12  | ADDI_WB    rt <= ALUOut
// 13-15| unused     return to FETCH
module micro_seq
    import micro_defs::*;
#(
    parameter int UPC_W      = 4,
    parameter int FETCH_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    micro_seq_if.master   bus
);

    logic [UPC_W-1:0] upc_q;
    logic [UPC_W-1:0] upc_n;
    logic [UPC_W-1:0] disp1_addr;
    logic [UPC_W-1:0] disp2_addr;
    logic             disp1_illegal;
    logic             illegal_q;
    logic             mem_go;
    ctrl_word_t       word;

    micro_rom #(.UPC_W(UPC_W)) u_rom (
        .upc  (upc_q),
        .word (word)
    );

    always_comb begin
        disp1_illegal = 1'b0;
        case (bus.op)
            OP_RTYPE:     disp1_addr = UPC_W'(S_R_EXEC);
            OP_LW, OP_SW: disp1_addr = UPC_W'(S_MEM_ADDR);
            OP_BEQ:       disp1_addr = UPC_W'(S_BEQ);
            OP_J:         disp1_addr = UPC_W'(S_J);
            OP_JAL:       disp1_addr = UPC_W'(S_JAL);
            OP_ADDI:      disp1_addr = UPC_W'(S_ADDI_EXEC);
            default: begin
                disp1_addr    = UPC_W'(FETCH_ADDR);
                disp1_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_LW:   disp2_addr = UPC_W'(S_LW_READ);
            OP_SW:   disp2_addr = UPC_W'(S_SW_WRITE);
            default: disp2_addr = UPC_W'(FETCH_ADDR);
        endcase
    end

    // Non-memory words never wait, so mem_ready is irrelevant outside them.
    assign mem_go = ~word.mem_state | bus.mem_ready;

    always_comb begin
        case (word.next)
            NA_FETCH: upc_n = UPC_W'(FETCH_ADDR);
            NA_DISP1: upc_n = disp1_addr;
            NA_DISP2: upc_n = disp2_addr;
            default:  upc_n = upc_q + UPC_W'(1);
        endcase
        if (!mem_go) begin
            upc_n = upc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upc_q     <= UPC_W'(FETCH_ADDR);
            illegal_q <= 1'b0;
        end else begin
            upc_q     <= upc_n;
            illegal_q <= (word.next == NA_DISP1) & disp1_illegal;
        end
    end

    // Strobes are blanked during reset; selects keep following the word.
    // ir_write/pc_write fire only on the completing cycle of a memory wait.
    assign bus.pc_en      = ~rst & ((word.pc_write & mem_go) | (word.branch & bus.zero));
    assign bus.mem_read   = ~rst & word.mem_read;
    assign bus.mem_write  = ~rst & word.mem_write;
    assign bus.ir_write   = ~rst & word.ir_write & mem_go;
    assign bus.reg_write  = ~rst & word.reg_write;
    assign bus.iord       = word.iord;
    assign bus.reg_dst    = word.reg_dst;
    assign bus.mem_to_reg = word.mem_to_reg;
    assign bus.alu_src_a  = word.alu_src_a;
    assign bus.alu_src_b  = word.alu_src_b;
    assign bus.alu_op     = word.alu_op;
    assign bus.pc_src     = word.pc_src;
    assign bus.upc        = upc_q;
    assign bus.illegal_op = illegal_q;

endmodule

// File: doc/micro_seq.md
Name: micro_seq

Overview:
- Microprogrammed control sequencer for the multicycle MIPS datapath.
- Holds a micro-PC (uPC) and an internal microcode ROM, and selects the next uPC by sequencing, opcode dispatch or return-to-fetch.
- Drives all datapath control strobes and select fields, including reg_dst[1:0], the select input of the 5-bit 4:1 write-register-address mux (0=rt, 1=rd, 2=r31).
- Stalls on memory micro-states until the memory handshake completes.

Parameters:
- UPC_W, 4, width of uPC and of every microcode/dispatch address.
- FETCH_ADDR, 0, uPC value of the FETCH micro-instruction; reset and return target.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  instruction opcode IR[31:26]; sampled only in DECODE and MEM_ADDR.
- zero  in  1  ALU zero flag; used in BEQ.
- mem_ready  in  1  memory done; completes the current access.
- pc_en  out  1  PC load = pc_write | (branch & zero).
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  write-register select: 0=rt, 1=rd, 2=r31, 3=reserved (never driven).
- mem_to_reg  out  2  write data select: 0=ALUOut, 1=MDR, 2=PC.
- alu_src_a  out  1  0=PC, 1=A.
- alu_src_b  out  2  0=B, 1=const 4, 2=signext imm, 3=signext imm<<2.
- alu_op  out  2  0=add, 1=sub, 2=funct-decoded.
- pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target.
- upc  out  UPC_W  current uPC (debug/verification).
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

Behaviour:
- Outputs are combinational from the current uPC's microcode word (Moore form). uPC is the only register besides illegal_op.
- Reset: while rst=1, uPC<=FETCH_ADDR on each edge and illegal_op<=0. All strobes (pc_en, mem_read, mem_write, ir_write, reg_write) are forced 0 during reset. Select fields show the FETCH word.
- Reset wins over everything, including mid-instruction and mid-stall.
- Next-address field per word: 0=FETCH, 1=dispatch1(op), 2=dispatch2(op), 3=uPC+1.
- Micro-states (uPC: name, asserted controls, next):
  - 0 FETCH: mem_read, iord=0, ir_write, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0, pc_write; next=+1.
  - 1 DECODE: alu_src_a=0, alu_src_b=3, alu_op=0; next=dispatch1.
  - 2 MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0; next=dispatch2.
  - 3 LW_READ: mem_read, iord=1; next=+1.
  - 4 LW_WB: reg_write, reg_dst=0, mem_to_reg=1; next=FETCH.
  - 5 SW_WRITE: mem_write, iord=1; next=FETCH.
  - 6 R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=2; next=+1.
  - 7 R_WB: reg_write, reg_dst=1, mem_to_reg=0; next=FETCH.
  - 8 BEQ: alu_src_a=1, alu_src_b=0, alu_op=1, branch, pc_src=1; next=FETCH.
  - 9 J: pc_write, pc_src=2; next=FETCH.
  - 10 JAL: reg_write, reg_dst=2, mem_to_reg=2, pc_write, pc_src=2 (writes PC+4 to r31 and jumps in the same cycle); next=FETCH.
  - 11 ADDI_EXEC: alu_src_a=1, alu_src_b=2, alu_op=0; next=+1.
  - 12 ADDI_WB: reg_write, reg_dst=0, mem_to_reg=0; next=FETCH.
  - 13–15: unused; all strobes 0, next=FETCH.
- Dispatch1 (opcode -> uPC):
  - 000000 -> 6
  - 100011 and 101011 -> 2
  - 000100 -> 8
  - 000010 -> 9
  - 000011 -> 10
  - 001000 -> 11
  - any other opcode -> FETCH, with illegal_op=1 for exactly the following cycle.
- Dispatch2 (opcode -> uPC): 100011 -> 3; 101011 -> 5; any other opcode -> FETCH (unreachable).
- Memory handshake (states 0, 3, 5):
  - uPC holds while mem_ready=0.
  - mem_read/mem_write stay asserted throughout the wait.
  - ir_write and pc_write are qualified by mem_ready, so PC and IR update exactly once.
  - Advance happens on the edge where mem_ready=1. A mem_ready=1 already present on the first cycle gives zero wait.
  - mem_ready is ignored in all non-memory states.
- Latency (mem_ready tied 1):
  - R-type, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ, J, JAL: 3 cycles.

Decomposition:
- Shared package (micro_defs): uPC state constants, next-address codes, opcode constants, and the reg_dst, mem_to_reg, alu_src_b, alu_op and pc_src encodings. The datapath and the 5-bit mux share these.
- One natural sub-module: micro_rom (uPC -> control word plus next-address field, purely combinational).
- Dispatch tables and the uPC register stay in micro_seq.

Test Plan:
- R-type, op=000000, mem_ready=1: upc 0->1->6->7->0. In state 7: reg_write=1, reg_dst=1, mem_to_reg=0.
- LW, op=100011, with mem_ready held low 2 cycles in LW_READ: upc 0,1,2,3,3,3,4,0. mem_read held high in state 3. In state 4: reg_dst=0, mem_to_reg=1.
- JAL, op=000011: upc 0->1->10->0. In state 10: reg_write=1, reg_dst=2, mem_to_reg=2, pc_en=1, pc_src=2, all in one cycle.
- BEQ, op=000100: with zero=1, pc_en=1 and pc_src=1 in state 8; with zero=0, pc_en=0. Either way next upc=0.
- Illegal op=111111: upc 1->0, illegal_op=1 for exactly one cycle, no reg_write or mem_write at any point.
- rst=1 asserted while in upc=3 with mem_ready=0: next edge gives upc=0, strobes 0 while rst=1. After release, FETCH begins normally.
